// File: rtl/sg_pkg.sv
// ---------------------------------------------------------------------------
// sg_pkg
//
// Shared definitions for the filtered-sample UART transmitter slice.
//
// Contents:
//    DATA_W_DEFAULT  - default width of one filtered-sample word (bits)
//    BYTES_PER_WORD  - number of serial bytes a default-width word becomes
//    tx_state_t      - serial FSM states (IDLE, START, DATA, STOP)
//    bytes_per_word  - helper that turns any word width into a byte count
// ---------------------------------------------------------------------------
package sg_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

    // One state per UART bit class; a byte is START + 8 x DATA + STOP.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Word widths are always whole bytes, so a plain divide is exact.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage : sg_pkg

// File: rtl/sg_fifo.sv
// ---------------------------------------------------------------------------
// sg_fifo
//
// Synchronous single-clock word FIFO that decouples the filtered-sample
// producer from the much slower serial transmitter.
//
// Ports:
//    clk        - clock, all logic on the rising edge
//    rst        - synchronous active-high reset, empties the buffer
//    i_push     - write request; ignored while full
//    i_pushData - word to write
//    i_pop      - read request; ignored while empty
//    o_popData  - word at the head of the FIFO (valid while !o_empty)
//    o_full     - count equals DEPTH
//    o_empty    - count equals zero
//    o_count    - registered number of stored words (0..DEPTH)
//
// DEPTH must be a power of two (at least 2) so the pointers wrap for free.
// ---------------------------------------------------------------------------
module sg_fifo
    import sg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_pushData,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_popData,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              w_doPush;
    logic              w_doPop;

    // Status comes straight from the registered count, so full and empty
    // never glitch and a pop from full only frees a slot on the next cycle.
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    // Requests that cannot be honoured are dropped here, which keeps the
    // pointers and count consistent even if a caller misbehaves.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Head word is read combinationally so the transmitter can load it on
    // the same edge that it pops.
    assign o_popData = r_mem[r_rdPtr];

    // Storage array: written on accepted pushes only, never reset since the
    // count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally at DEPTH; the count moves only when exactly
    // one of push/pop happens, so a simultaneous push and pop leaves it put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sg_fifo

// File: rtl/sg_result_tx.sv
// ---------------------------------------------------------------------------
// sg_result_tx
//
// Buffers filtered-sample words and ships them out over a UART 8N1 line,
// least-significant byte first, each byte LSB first.  Words of one frame
// and consecutive frames are sent back to back with no idle bits.
//
// Parameters:
//    DATA_W       - sample word width, multiple of 8
//    FIFO_DEPTH   - word buffer depth, power of two
//    CLKS_PER_BIT - clk cycles per serial bit, at least 2
//
// Ports:
//    clk        - clock, all logic on the rising edge
//    rst        - synchronous active-high reset; aborts any frame in flight
//    in_valid   - in_data holds a sample
//    in_data    - two's-complement sample, sent bit-exact
//    in_ready   - a word can be accepted this cycle (buffer not full)
//    tx         - serial line, idle high
//    busy       - a word is being shifted out
//    fifo_count - number of buffered words
//    frame_done - one-cycle pulse as the last stop bit of a word ends
// ---------------------------------------------------------------------------
module sg_result_tx
    import sg_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);

    localparam int NBYTES = bytes_per_word(DATA_W);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE    = BW'(NBYTES - 1);

    tx_state_t         r_state;
    tx_state_t         w_nextState;
    logic [TW-1:0]     r_bitTimer;
    logic [2:0]        r_bitIdx;
    logic [BW-1:0]     r_byteIdx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shiftNext;
    logic              r_tx;
    logic              w_txNext;
    logic              r_frameDone;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifoData;
    logic              w_bitEnd;
    logic              w_loadTimer;
    logic              w_shiftBit;
    logic              w_nextByte;
    logic              w_frameEnd;

    // in_ready depends only on the registered full flag: there is no path
    // that lets a word slip through while the buffer is full, even if the
    // transmitter is popping on the same edge.  Pushes are dropped in reset.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !rst;

    sg_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (in_data),
        .i_pop      (w_pop),
        .o_popData  (w_fifoData),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (fifo_count)
    );

    // The bit timer counts down from CLKS_PER_BIT-1; reaching zero marks the
    // last cycle of the current bit.
    assign w_bitEnd = (r_bitTimer == '0);

    // Next-state and control decode.  Every bit transition reloads the
    // timer.  Leaving the last STOP of a word raises frame_done and, if the
    // buffer holds another word, pops it and goes straight into START so
    // consecutive frames abut.  The shift register loads on a pop and moves
    // one place right per DATA bit, so r_shift[0] is always the bit on air;
    // after eight shifts the next byte of the word is already in place.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_loadTimer = 1'b0;
        w_shiftBit  = 1'b0;
        w_nextByte  = 1'b0;
        w_frameEnd  = 1'b0;
        w_shiftNext = r_shift;
        w_txNext    = 1'b1;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_loadTimer = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    w_shiftBit  = 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bitEnd) begin
                    w_loadTimer = 1'b1;
                    if (r_byteIdx == LAST_BYTE) begin
                        w_frameEnd = 1'b1;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_nextState = START;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end else begin
                        w_nextByte  = 1'b1;
                        w_nextState = START;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_pop) begin
            w_shiftNext = w_fifoData;
        end else if (w_shiftBit) begin
            w_shiftNext = r_shift >> 1;
        end

        case (w_nextState)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers.  tx is registered from the next-state decode so
    // the line is glitch-free and falls on the very edge that pops a word.
    // Reset forces the line high at once, abandoning any frame in flight
    // without a frame_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitTimer  <= '0;
            r_bitIdx    <= '0;
            r_byteIdx   <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_frameDone <= 1'b0;
        end else begin
            if (w_loadTimer) begin
                r_bitTimer <= TIMER_RELOAD;
            end else if (!w_bitEnd) begin
                r_bitTimer <= r_bitTimer - TW'(1);
            end

            if (w_pop) begin
                r_bitIdx <= '0;
            end else if (w_shiftBit) begin
                r_bitIdx <= r_bitIdx + 3'd1;
            end

            if (w_pop) begin
                r_byteIdx <= '0;
            end else if (w_nextByte) begin
                r_byteIdx <= r_byteIdx + BW'(1);
            end

            r_shift     <= w_shiftNext;
            r_tx        <= w_txNext;
            r_frameDone <= w_frameEnd;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frameDone;

endmodule : sg_result_tx

// File: tb/tb_sg_result_tx.sv
// ---------------------------------------------------------------------------
// tb_sg_result_tx
//
// Directed bench for sg_result_tx with CLKS_PER_BIT=4, DATA_W=32,
// FIFO_DEPTH=16.  A free-running UART receiver decodes the tx line into a
// byte queue that the scenario tasks compare against hand-computed words.
// ---------------------------------------------------------------------------
module tb_sg_result_tx;

    localparam int DATA_W       = 32;
    localparam int FIFO_DEPTH   = 16;
    localparam int CLKS_PER_BIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        frame_done;

    int          checksTotal  = 0;
    int          checksPassed = 0;
    int          cycleCount   = 0;
    int          frameErrors  = 0;
    logic [7:0]  rxBytes [$];
    logic [31:0] expQ [$];
    logic [7:0]  monByte;

    sg_result_tx #(
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .frame_done (frame_done)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Free-running edge counter used to time latencies.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // UART receiver: a low seen on a falling edge is confirmed one cycle
    // later, then every bit is sampled 1.5 cycles into its 4-cycle slot.
    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                @(negedge clk);
                if (tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (CLKS_PER_BIT) @(negedge clk);
                        monByte[k] = tx;
                    end
                    repeat (CLKS_PER_BIT) @(negedge clk);
                    if (tx !== 1'b1) frameErrors++;
                    rxBytes.push_back(monByte);
                end
            end
        end
    end

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        tick(3);
        checksTotal++;
        if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b want 1", tx); else checksPassed++;
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else checksPassed++;
        checksTotal++;
        if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); else checksPassed++;
        checksTotal++;
        if (fifo_count !== 5'd0) $display("[TB] FAIL reset_count: got %0d want 0", fifo_count); else checksPassed++;
        checksTotal++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else checksPassed++;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick(1);
        checksTotal++;
        if (fifo_count !== 5'd0 || tx !== 1'b1)
            $display("[TB] FAIL reset_valid_ignored: got count=%0d tx=%b want count=0 tx=1", fifo_count, tx);
        else checksPassed++;
    endtask

    task automatic test_single_word;
        logic [39:0] obs;
        int          n;
        obs = '0;
        rxBytes.delete();
        in_valid = 1'b1;
        in_data  = 32'h0000_00A5;
        tick(1);
        in_valid = 1'b0;
        checksTotal++;
        if (tx !== 1'b1 || fifo_count !== 5'd1)
            $display("[TB] FAIL single_accept: got tx=%b count=%0d want tx=1 count=1", tx, fifo_count);
        else checksPassed++;
        tick(1);
        checksTotal++;
        if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd0)
            $display("[TB] FAIL single_latency: got tx=%b busy=%b count=%0d want tx=0 busy=1 count=0", tx, busy, fifo_count);
        else checksPassed++;
        n = 0;
        while (n < 400 && frame_done !== 1'b1) begin
            if (n % CLKS_PER_BIT == 0 && n < 160) obs[n / CLKS_PER_BIT] = tx;
            tick(1);
            n++;
        end
        checksTotal++;
        if (obs[9:0] !== 10'b1101001010)
            $display("[TB] FAIL single_line_byte0: got %b want 1101001010", obs[9:0]);
        else checksPassed++;
        checksTotal++;
        if (obs[39:10] !== {10'b1000000000, 10'b1000000000, 10'b1000000000})
            $display("[TB] FAIL single_line_zero_bytes: got %b", obs[39:10]);
        else checksPassed++;
        checksTotal++;
        if (n != 160) $display("[TB] FAIL single_frame_done_latency: got %0d want 160", n); else checksPassed++;
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL single_idle_after: got busy=%b want 0", busy); else checksPassed++;
        tick(1);
        checksTotal++;
        if (frame_done !== 1'b0 || tx !== 1'b1)
            $display("[TB] FAIL single_pulse_width: got frame_done=%b tx=%b want 0/1", frame_done, tx);
        else checksPassed++;
        checksTotal++;
        if (rxBytes.size() != 4 || rxBytes[0] !== 8'hA5 || rxBytes[1] !== 8'h00 ||
            rxBytes[2] !== 8'h00 || rxBytes[3] !== 8'h00)
            $display("[TB] FAIL single_decode: got %0d bytes want A5 00 00 00", rxBytes.size());
        else checksPassed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] expBytes [8];
        int         t0, f1, f2, pulses, idleCycles, n, bad;
        expBytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        rxBytes.delete();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        tick(1);
        in_data  = 32'hCAFE_F00D;
        tick(1);
        in_valid = 1'b0;
        t0 = cycleCount;
        checksTotal++;
        if (fifo_count !== 5'd1 || tx !== 1'b0)
            $display("[TB] FAIL b2b_push_pop_count: got count=%0d tx=%b want 1/0", fifo_count, tx);
        else checksPassed++;
        f1 = 0; f2 = 0; pulses = 0; idleCycles = 0; n = 0;
        while (pulses < 2 && n < 600) begin
            tick(1);
            n++;
            if (frame_done === 1'b1) begin
                pulses++;
                if (pulses == 1) f1 = cycleCount; else f2 = cycleCount;
            end
            if (pulses < 2 && busy !== 1'b1) idleCycles++;
        end
        checksTotal++;
        if (pulses != 2) $display("[TB] FAIL b2b_pulses: got %0d want 2", pulses); else checksPassed++;
        checksTotal++;
        if (f1 - t0 != 160) $display("[TB] FAIL b2b_first_latency: got %0d want 160", f1 - t0); else checksPassed++;
        checksTotal++;
        if (f2 - f1 != 160) $display("[TB] FAIL b2b_spacing: got %0d want 160", f2 - f1); else checksPassed++;
        checksTotal++;
        if (idleCycles != 0) $display("[TB] FAIL b2b_gap: got %0d idle cycles want 0", idleCycles); else checksPassed++;
        tick(2);
        bad = 0;
        if (rxBytes.size() != 8) bad = 8;
        else for (int i = 0; i < 8; i++) if (rxBytes[i] !== expBytes[i]) bad++;
        checksTotal++;
        if (bad != 0) $display("[TB] FAIL b2b_decode: got %0d bad bytes of %0d received want 0", bad, rxBytes.size());
        else checksPassed++;
    endtask

    task automatic test_fill_and_refill;
        int          accepted, peak, n, bad;
        logic        wasReady;
        logic [31:0] got;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expQ.delete();
        rxBytes.delete();
        accepted = 0;
        peak     = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000_0000 + 32'(i);
            wasReady = in_ready;
            tick(1);
            if (wasReady) begin
                accepted++;
                expQ.push_back(in_data);
            end
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (i == 1) begin
                checksTotal++;
                if (fifo_count !== 5'd1) $display("[TB] FAIL fill_push_pop_count: got %0d want 1", fifo_count);
                else checksPassed++;
            end
        end
        checksTotal++;
        if (accepted != 17) $display("[TB] FAIL fill_accepted: got %0d want 17", accepted); else checksPassed++;
        checksTotal++;
        if (peak != 16) $display("[TB] FAIL fill_peak: got %0d want 16", peak); else checksPassed++;
        checksTotal++;
        if (in_ready !== 1'b0 || fifo_count !== 5'd16)
            $display("[TB] FAIL fill_full: got in_ready=%b count=%0d want 0/16", in_ready, fifo_count);
        else checksPassed++;

        in_data  = 32'hDEAD_BEEF;
        wasReady = 1'b0;
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin
            wasReady = in_ready;
            tick(1);
            n++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        checksTotal++;
        if (frame_done !== 1'b1 || wasReady !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL refill_ready_rise: got pulse=%b ready_at_pop=%b ready_after=%b want 1/0/1",
                     frame_done, wasReady, in_ready);
        else checksPassed++;
        tick(1);
        expQ.push_back(32'hDEAD_BEEF);
        in_valid = 1'b0;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        checksTotal++;
        if (fifo_count !== 5'd16 || in_ready !== 1'b0 || peak != 16)
            $display("[TB] FAIL refill_count: got count=%0d in_ready=%b peak=%0d want 16/0/16",
                     fifo_count, in_ready, peak);
        else checksPassed++;

        n = 0;
        while (rxBytes.size() < expQ.size() * 4 && n < 4000) begin
            tick(1);
            n++;
        end
        bad = 0;
        if (rxBytes.size() < expQ.size() * 4) bad = expQ.size();
        else for (int w = 0; w < expQ.size(); w++) begin
            got = {rxBytes[4*w+3], rxBytes[4*w+2], rxBytes[4*w+1], rxBytes[4*w]};
            if (got !== expQ[w]) bad++;
        end
        checksTotal++;
        if (bad != 0) $display("[TB] FAIL fill_drain_order: got %0d bad words want 0", bad); else checksPassed++;
        tick(20);
    endtask

    task automatic test_reset_mid_frame;
        int pulses, busyCycles;
        rxBytes.delete();
        in_valid = 1'b1;
        in_data  = 32'hA1B2_C3D4;
        tick(1);
        in_data  = 32'h1111_1111;
        tick(1);
        in_data  = 32'h2222_2222;
        tick(1);
        in_valid = 1'b0;
        tick(93);
        checksTotal++;
        if (busy !== 1'b1 || fifo_count !== 5'd2)
            $display("[TB] FAIL midreset_pre: got busy=%b count=%0d want 1/2", busy, fifo_count);
        else checksPassed++;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h3333_3333;
        tick(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        checksTotal++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || frame_done !== 1'b0)
            $display("[TB] FAIL midreset_abort: got tx=%b busy=%b count=%0d fd=%b want 1/0/0/0",
                     tx, busy, fifo_count, frame_done);
        else checksPassed++;
        pulses = 0;
        busyCycles = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (frame_done === 1'b1) pulses++;
            if (busy !== 1'b0 || tx !== 1'b1) busyCycles++;
        end
        checksTotal++;
        if (pulses != 0 || busyCycles != 0)
            $display("[TB] FAIL midreset_quiet: got %0d pulses %0d active cycles want 0/0", pulses, busyCycles);
        else checksPassed++;
        rxBytes.delete();
        frameErrors = 0;
    endtask

    task automatic test_stress;
        int          accepted, n, bad;
        logic        wasReady;
        logic [31:0] got;
        expQ.delete();
        rxBytes.delete();
        frameErrors = 0;
        accepted = 0;
        n = 0;
        while (accepted < 200 && n < 60000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            wasReady = in_ready;
            tick(1);
            n++;
            if (in_valid && wasReady) begin
                accepted++;
                expQ.push_back(in_data);
            end
        end
        in_valid = 1'b0;
        checksTotal++;
        if (accepted != 200) $display("[TB] FAIL stress_accepted: got %0d want 200", accepted); else checksPassed++;
        n = 0;
        while (rxBytes.size() < expQ.size() * 4 && n < 40000) begin
            tick(1);
            n++;
        end
        checksTotal++;
        if (rxBytes.size() != expQ.size() * 4)
            $display("[TB] FAIL stress_byte_count: got %0d want %0d", rxBytes.size(), expQ.size() * 4);
        else checksPassed++;
        bad = 0;
        if (rxBytes.size() < expQ.size() * 4) bad = expQ.size();
        else for (int w = 0; w < expQ.size(); w++) begin
            got = {rxBytes[4*w+3], rxBytes[4*w+2], rxBytes[4*w+1], rxBytes[4*w]};
            if (got !== expQ[w]) bad++;
        end
        checksTotal++;
        if (bad != 0) $display("[TB] FAIL stress_words: got %0d bad words want 0", bad); else checksPassed++;
        checksTotal++;
        if (frameErrors != 0) $display("[TB] FAIL stress_framing: got %0d stop-bit errors want 0", frameErrors);
        else checksPassed++;
    endtask

    // Scenario sequence.
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fill_and_refill();
        test_reset_mid_frame();
        test_stress();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule : tb_sg_result_tx

// File: doc/sg_result_tx.md
SG_RESULT_TX -- requirements
Module: sg_result_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the filtered-sample word width, which must be a multiple of 8.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the word buffer depth, which must be a power of two.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning the number of clk cycles per serial bit (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a filtered sample.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: the filtered sample in two's-complement fixed point.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The block SHALL have port tx, output, 1 bit: the UART 8N1 serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a word is being shifted out.
REQ-011 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of buffered words.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when a word's last stop bit completes.

Function
REQ-013 A word SHALL be accepted on a posedge where in_valid && in_ready; in_ready = !fifo_full, with no same-cycle pass-through when full.
REQ-014 Words SHALL be transmitted in acceptance order as DATA_W/8 bytes, least-significant byte first, each byte LSB first.
REQ-015 The serial FSM SHALL have states IDLE, START, DATA, STOP; every bit SHALL be held exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads on each bit.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop one word into the shift register on the next edge, enter START, and drive tx low.
REQ-017 Latency: a word accepted at edge N into an empty FIFO with the FSM idle SHALL drive tx low from edge N+1.
REQ-018 DATA SHALL shift 8 bits; STOP SHALL drive tx high; after STOP, the FSM SHALL go to START for the next byte of the same word with no idle gap.
REQ-019 After the last byte's STOP, the FSM SHALL pulse frame_done for one cycle; if the FIFO is non-empty it SHALL pop and enter START on the same edge, otherwise it SHALL enter IDLE.
REQ-020 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 A pop from a full FIFO SHALL raise in_ready on the following cycle.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full SHALL be fifo_count==FIFO_DEPTH and empty SHALL be fifo_count==0.
REQ-023 busy SHALL be high in START, DATA, and STOP, and low in IDLE.
REQ-024 in_data SHALL be transmitted bit-exact, with no rounding or saturation.

Reset
REQ-025 On rst high at a posedge, the block SHALL set tx=1, busy=0, frame_done=0, fifo_count=0, and in_ready=1, with the FSM in IDLE and the timers cleared.
REQ-026 A reset asserted mid-frame SHALL abort the frame: tx returns high the next cycle, buffered words are discarded, and no frame_done is issued.
REQ-027 While rst is high, in_valid SHALL be ignored.

Structure
REQ-028 Package sg_pkg SHALL hold the DATA_W default, the BYTES_PER_WORD constant, and the tx_state_t enum {IDLE, START, DATA, STOP}.
REQ-029 The FIFO SHALL be a separate sub-module sg_fifo (synchronous, registered count, full/empty outputs); the FSM and shifter SHALL reside in sg_result_tx.

Verification (CLKS_PER_BIT=4, DATA_W=32, FIFO_DEPTH=16)
REQ-030 The bench SHALL push 0x000000A5 when idle: tx falls 1 cycle after acceptance; line sequence 0,1,0,1,0,0,1,0,1,1 then three bytes of 0x00 framing; frame_done exactly 160 cycles after tx falls.
REQ-031 The bench SHALL push 0x12345678 then 0xCAFEF00D back-to-back: bytes 78,56,34,12,0D,F0,FE,CA decoded with no idle cycles between frames, and two frame_done pulses 160 cycles apart.
REQ-032 The bench SHALL hold in_valid high for 20 words from reset: exactly 17 are accepted before in_ready drops; fifo_count peaks at 16.
REQ-033 The bench SHALL push one word into a full FIFO during the pop at the end of a frame: fifo_count stays at 16 and in_ready rises 1 cycle after the pop.
REQ-034 The bench SHALL assert rst during the DATA state of byte 2: the next cycle shows tx=1, busy=0, fifo_count=0, and no frame_done pulse.
REQ-035 The bench SHALL run a 200-random-word stress with random in_valid: a UART monitor reconstructs all words in order with zero mismatches.
